array_mult_arbiter: RTL
=======================

Name: array_mult_arbiter

Overview:
- Shares one combinational array multiplier between two requesters; the multiplier sits outside this block.
- Round-robin arbitration; registers the granted operands onto the multiplier inputs.
- Holds those inputs stable for a programmable settle window (multicycle path through the array), then captures the product.
- Returns the product on a valid/ready response channel, tagged with the requester ID.

Parameters:
BITS, 64, operand width; product width is 2*BITS
SETTLE_CYCLES, 4, cycles the multiplier inputs are held before the product is sampled; legal range 1..255

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  BITS  requester 0 multiplicand
req0_b  in  BITS  requester 0 multiplier
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 operands accepted this cycle
req1_a  in  BITS  requester 1 multiplicand
req1_b  in  BITS  requester 1 multiplier
mul_a  out  BITS  registered operand to the array multiplier
mul_b  out  BITS  registered operand to the array multiplier
mul_p  in  2*BITS  combinational product from the array multiplier
resp_valid  out  1  product available
resp_ready  in  1  consumer accepts the product
resp_p  out  2*BITS  registered product
resp_id  out  1  requester that issued the operation
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high. All state updates on the rising edge of `clk`.
- Reset values: state=IDLE, mul_a=0, mul_b=0, resp_valid=0, resp_p=0, resp_id=0, busy=0, settle counter=0, last_grant=1 (so requester 0 wins the first contest).
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready is combinational: reqN_ready = IDLE & reqN_valid & granted(N).
  - Only one ready is ever high in a cycle.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, grant the one that is not last_grant.
  - On the accepting edge:
    - mul_a/mul_b <= the granted operands.
    - resp_id <= granted index.
    - last_grant <= granted index.
    - counter <= SETTLE_CYCLES-1.
    - state -> SETTLE.
- SETTLE:
  - Both req_ready low.
  - mul_a/mul_b held constant.
  - If counter != 0: decrement.
  - If counter == 0: resp_p <= mul_p, resp_valid <= 1, state -> RESP.
  - Net latency: resp_valid rises exactly SETTLE_CYCLES edges after the accepting edge.
- RESP:
  - resp_valid high; resp_p and resp_id stable while resp_ready is low (unbounded stall allowed).
  - Both req_ready low.
  - On an edge with resp_ready=1: resp_valid <= 0, state -> IDLE.
  - No new request is accepted in the same cycle as a response handshake.
  - Steady-state throughput: one operation per SETTLE_CYCLES+2 cycles.
- mul_a/mul_b are not cleared after an operation; they keep their last value, which saves toggling the array.
- Arithmetic: unsigned. resp_p is the full 2*BITS product, no truncation; the block does no arithmetic on the data itself.
- reqN_a/b only need to be stable in the accepting cycle. Changes on a requester's inputs while it is not being accepted are ignored.
- A requester may deassert valid before being accepted; nothing is latched for it.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and all reset values apply on the next cycle.
- Starvation-free: with both requesters held valid, grants alternate 0,1,0,1,...

Decomposition:
- Shared package: FSM state enum (IDLE/SETTLE/RESP), the counter-width constant (8 bits, sized from the SETTLE_CYCLES maximum), and a requester ID type.
- One natural sub-module, `rr_arb2`: a two-way round-robin arbiter holding last_grant, with inputs valid[1:0] and enable, and outputs grant[1:0] and grant_idx.
- The FSM, counter and registers stay in the top level.
- The bench pairs this block with the existing array multiplier (BITS=8) on the mul_* ports.

Test Plan (BITS=8, SETTLE_CYCLES=2 unless noted):
1. Single op: req0 a=13, b=11, resp_ready held 1 -> req0_ready high for exactly 1 cycle; resp_valid rises 2 edges later with resp_p=143, resp_id=0; busy high for 3 cycles.
2. Contention: both valid from reset, req0 (5,7), req1 (200,255), resp_ready=1 -> first response 35/id 0, second 51000/id 1; then with both held valid, grants alternate.
3. Back-pressure: single op 255×255 with resp_ready=0 for 10 cycles -> resp_valid and resp_p=65025 held stable; both req_ready stay 0; the op completes only when resp_ready goes to 1.
4. Reset mid-op: assert rst during SETTLE -> next cycle resp_valid=0, mul_a=0, busy=0; no response ever appears for that op; the following req1 op (3×4) returns 12, id 1.
5. Latency sweep: SETTLE_CYCLES=1 and 5 -> resp_valid exactly 1 and 5 edges after acceptance; products for (0,x)=0 and (1,x)=x are correct.
6. Glitchy requester: req1 pulses valid while the block is in SETTLE, then drops -> no grant is recorded, no response with id 1 appears, and last_grant is unchanged.

Source files
------------

// File: rtl/array_mult_arbiter_pkg.sv
// Shared types and constants for the array multiplier arbiter:
// FSM state encoding, settle-counter width and requester ID type.
package array_mult_arbiter_pkg;

    // Largest supported settle window; the counter is sized to hold it.
    localparam int SETTLE_MAX = 255;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

endpackage

// File: rtl/array_mult_arbiter_if.sv
// Bundle of the two requester channels, the multiplier operand/product
// wires and the response channel. The arbiter uses the slave view; the
// requesters, multiplier and consumer together form the master view.
interface array_mult_arbiter_if #(
    parameter int BITS = 64
);
    logic              req0_valid;
    logic              req0_ready;
    logic [BITS-1:0]   req0_a;
    logic [BITS-1:0]   req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [BITS-1:0]   req1_a;
    logic [BITS-1:0]   req1_b;

    logic [BITS-1:0]   mul_a;
    logic [BITS-1:0]   mul_b;
    logic [2*BITS-1:0] mul_p;

    logic              resp_valid;
    logic              resp_ready;
    logic [2*BITS-1:0] resp_p;
    logic              resp_id;

    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output mul_a, mul_b,
        input  mul_p,
        output resp_valid, resp_p, resp_id,
        input  resp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  mul_a, mul_b,
        output mul_p,
        input  resp_valid, resp_p, resp_id,
        output resp_ready,
        input  busy
    );

endinterface

// File: rtl/array_mult_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone valid requester always wins; on a
// tie the requester that did not win the previous accepted contest wins.
// last_grant only moves when a grant is actually issued, so requests that
// appear while the arbiter is disabled leave no trace.
module rr_arb2
    import array_mult_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output req_id_t    o_grant_idx
);

    req_id_t    r_last_grant;
    logic [1:0] w_grant;
    req_id_t    w_grant_idx;

    // Choose the winner for this cycle; no grant at all while disabled.
    always_comb begin
        w_grant     = 2'b00;
        w_grant_idx = 1'b0;
        if (i_enable) begin
            case (i_valid)
                2'b01: begin
                    w_grant     = 2'b01;
                    w_grant_idx = 1'b0;
                end
                2'b10: begin
                    w_grant     = 2'b10;
                    w_grant_idx = 1'b1;
                end
                2'b11: begin
                    if (r_last_grant == 1'b1) begin
                        w_grant     = 2'b01;
                        w_grant_idx = 1'b0;
                    end else begin
                        w_grant     = 2'b10;
                        w_grant_idx = 1'b1;
                    end
                end
                default: begin
                    w_grant     = 2'b00;
                    w_grant_idx = 1'b0;
                end
            endcase
        end
    end

    // Remember who won the last accepted contest; starts at 1 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant_idx;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_grant_idx;

endmodule

// File: rtl/array_mult_arbiter.sv
// Shares one external combinational array multiplier between two
// requesters. The granted operand pair is registered onto the multiplier
// inputs and held for SETTLE_CYCLES cycles (a multicycle path through the
// array) before the product is captured and offered on the response
// channel with the requester ID. Legal SETTLE_CYCLES range is 1..255.
module array_mult_arbiter
    import array_mult_arbiter_pkg::*;
#(
    parameter int BITS          = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    array_mult_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [BITS-1:0]   r_mul_a;
    logic [BITS-1:0]   r_mul_b;
    logic [2*BITS-1:0] r_resp_p;
    logic              r_resp_valid;
    req_id_t           r_resp_id;

    logic              w_arb_en;
    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    req_id_t           w_grant_idx;

    assign w_valid = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_valid),
        .i_enable    (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the arbiter is only enabled in IDLE, so a response
    // handshake cycle can never also accept a request.
    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb_en = 1'b1;
                if (|w_grant) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand, counter and response registers. Operands are left in place
    // after an operation so the array does not toggle needlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_cnt        <= '0;
            r_resp_p     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_mul_a   <= w_grant_idx ? bus.req1_a : bus.req0_a;
                        r_mul_b   <= w_grant_idx ? bus.req1_b : bus.req0_b;
                        r_resp_id <= w_grant_idx;
                        r_cnt     <= CNT_LOAD;
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_p     <= bus.mul_p;
                        r_resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_p     = r_resp_p;
    assign bus.resp_id    = r_resp_id;
    assign bus.busy       = (r_state != IDLE);

endmodule
